// File: rtl/i2c_reg_bank.sv
// ---------------------------------------------------------------------------
// i2c_reg_bank
//
// Register bank terminating the I2C slave core's register request/response
// interface. Provides ID, scratch, GPIO and status registers plus a TX FIFO
// that forwards I2C-written bytes into the fabric as a valid/ready stream.
// Rejected writes get no reg_response, which makes the slave NACK the byte.
//
// Optional feature macro: I2C_REG_BANK_IRQ_EN
//   defined   : register 0x08 IRQ_ENABLE (RW, low 4 bits), irq is registered
//               OR of STATUS[3:0] & IRQ_ENABLE[3:0]
//   undefined : 0x08 is unmapped, irq tied low
//
// Ports:
//   clock, reset       system clock, synchronous active-high reset
//   reg_address        register address (I2C_REG_ADDRESS_WIDTH bits)
//   reg_is_write       1 = write, 0 = read
//   reg_request        one-cycle request strobe
//   reg_write_data     write data byte
//   reg_response       one-cycle accept strobe, one cycle after the request
//   reg_read_data      read data, held until the next accepted read
//   gpio_out           GPIO_OUT register
//   gpio_in            asynchronous GPIO inputs
//   tx_data/tx_valid   TX FIFO head / not-empty
//   tx_ready           consumer accepts the head entry
//   irq                level interrupt, active-high
// ---------------------------------------------------------------------------
module i2c_reg_bank #(
    parameter int         I2C_REG_ADDRESS_WIDTH = 8,
    parameter logic [7:0] ID_VALUE              = 8'hA5,
    parameter int         GPIO_WIDTH            = 8,
    parameter int         FIFO_DEPTH_LOG2       = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [I2C_REG_ADDRESS_WIDTH-1:0] reg_address,
    input  logic                             reg_is_write,
    input  logic                             reg_request,
    input  logic [7:0]                       reg_write_data,
    output logic                             reg_response,
    output logic [7:0]                       reg_read_data,
    output logic [GPIO_WIDTH-1:0]            gpio_out,
    input  logic [GPIO_WIDTH-1:0]            gpio_in,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             irq
);

    localparam int AW    = I2C_REG_ADDRESS_WIDTH;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << PW;

    localparam logic [AW-1:0] A_ID      = AW'(8'h00);
    localparam logic [AW-1:0] A_SCRATCH = AW'(8'h01);
    localparam logic [AW-1:0] A_GPIOOUT = AW'(8'h02);
    localparam logic [AW-1:0] A_GPIOIN  = AW'(8'h03);
    localparam logic [AW-1:0] A_STATUS  = AW'(8'h04);
    localparam logic [AW-1:0] A_COUNT   = AW'(8'h05);
    localparam logic [AW-1:0] A_FIFO    = AW'(8'h06);
    localparam logic [AW-1:0] A_CONTROL = AW'(8'h07);

    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic                  response_q, response_d;
    logic [7:0]            readData_q, readData_d;
    logic [7:0]            scratch_q, scratch_d;
    logic [GPIO_WIDTH-1:0] gpioOut_q, gpioOut_d;
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, syncPrev_q;
    logic                  overflow_q, overflow_d;
    logic                  gpioChanged_q, gpioChanged_d;
    logic [PW-1:0]         wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [PW:0]           count_q, count_d;
    logic [7:0]            mem_q [DEPTH];

    logic       empty, full, wrReq, rdReq, isFifo, isCtrl;
    logic       writeOk, accept, push, pop, flush, clrOvf, clrChg;
    logic [7:0] status, countByte, gpioInByte, gpioOutByte, readMux;
    logic       irqEnHit;
    logic [3:0] irqEnByte;

`ifdef I2C_REG_BANK_IRQ_EN
    localparam logic [AW-1:0] A_IRQEN = AW'(8'h08);
    logic [3:0] irqEn_q, irqEn_d;
    logic       irq_q, irq_d;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    // Request decode: which access is accepted and which FIFO/flag side
    // effects it triggers. Full is taken from registered state so a push
    // into a full FIFO is rejected even when a pop happens in the same cycle.
    always_comb begin
        wrReq    = reg_request && reg_is_write;
        rdReq    = reg_request && !reg_is_write;
        isFifo   = (reg_address == A_FIFO);
        isCtrl   = (reg_address == A_CONTROL);
`ifdef I2C_REG_BANK_IRQ_EN
        irqEnHit = (reg_address == A_IRQEN);
`else
        irqEnHit = 1'b0;
`endif
        writeOk  = (reg_address == A_SCRATCH) || (reg_address == A_GPIOOUT) ||
                   isCtrl || (isFifo && !full) || irqEnHit;
        accept   = rdReq || (wrReq && writeOk);
        push     = wrReq && isFifo && !full;
        pop      = !empty && tx_ready;
        flush    = wrReq && isCtrl && reg_write_data[0];
        clrOvf   = wrReq && isCtrl && reg_write_data[1];
        clrChg   = wrReq && isCtrl && reg_write_data[2];
    end

    // Zero-extended views of narrower fields, and the read mux itself.
    // Unmapped and write-only addresses read as zero.
    always_comb begin
        countByte             = '0;
        countByte[PW:0]       = count_q;
        gpioInByte            = '0;
        gpioInByte[GPIO_WIDTH-1:0]  = sync2_q;
        gpioOutByte           = '0;
        gpioOutByte[GPIO_WIDTH-1:0] = gpioOut_q;
        status                = {4'b0000, gpioChanged_q, overflow_q, full, empty};
        irqEnByte             = 4'b0000;
`ifdef I2C_REG_BANK_IRQ_EN
        irqEnByte             = irqEn_q;
`endif
        readMux               = 8'h00;
        if (reg_address == A_ID)           readMux = ID_VALUE;
        else if (reg_address == A_SCRATCH) readMux = scratch_q;
        else if (reg_address == A_GPIOOUT) readMux = gpioOutByte;
        else if (reg_address == A_GPIOIN)  readMux = gpioInByte;
        else if (reg_address == A_STATUS)  readMux = status;
        else if (reg_address == A_COUNT)   readMux = countByte;
        else if (irqEnHit)                 readMux = {4'b0000, irqEnByte};
    end

    // Next-state logic for registers, FIFO bookkeeping and sticky flags.
    // Flush overrides any same-cycle pop; set beats clear on sticky flags.
    always_comb begin
        response_d    = accept;
        readData_d    = rdReq ? readMux : readData_q;
        scratch_d     = (wrReq && reg_address == A_SCRATCH) ? reg_write_data : scratch_q;
        gpioOut_d     = (wrReq && reg_address == A_GPIOOUT) ?
                        reg_write_data[GPIO_WIDTH-1:0] : gpioOut_q;
        overflow_d    = (wrReq && isFifo && full) || (overflow_q && !clrOvf);
        gpioChanged_d = (sync2_q != syncPrev_q) || (gpioChanged_q && !clrChg);
        wrPtr_d       = push ? wrPtr_q + PTR_ONE : wrPtr_q;
        rdPtr_d       = pop  ? rdPtr_q + PTR_ONE : rdPtr_q;
        count_d       = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (!push && pop) count_d = count_q - CNT_ONE;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
`ifdef I2C_REG_BANK_IRQ_EN
        irqEn_d = (wrReq && irqEnHit) ? reg_write_data[3:0] : irqEn_q;
        irq_d   = |(status[3:0] & irqEn_q);
`endif
    end

    // State registers with synchronous reset; a reset in the request cycle
    // drops the pending response and clears the FIFO and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            response_q    <= 1'b0;
            readData_q    <= 8'h00;
            scratch_q     <= 8'h00;
            gpioOut_q     <= '0;
            sync1_q       <= '0;
            sync2_q       <= '0;
            syncPrev_q    <= '0;
            overflow_q    <= 1'b0;
            gpioChanged_q <= 1'b0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
`ifdef I2C_REG_BANK_IRQ_EN
            irqEn_q       <= 4'b0000;
            irq_q         <= 1'b0;
`endif
        end else begin
            response_q    <= response_d;
            readData_q    <= readData_d;
            scratch_q     <= scratch_d;
            gpioOut_q     <= gpioOut_d;
            sync1_q       <= gpio_in;
            sync2_q       <= sync1_q;
            syncPrev_q    <= sync2_q;
            overflow_q    <= overflow_d;
            gpioChanged_q <= gpioChanged_d;
            wrPtr_q       <= wrPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
`ifdef I2C_REG_BANK_IRQ_EN
            irqEn_q       <= irqEn_d;
            irq_q         <= irq_d;
`endif
        end
    end

    // FIFO storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wrPtr_q] <= reg_write_data;
    end

    assign reg_response  = response_q;
    assign reg_read_data = readData_q;
    assign gpio_out      = gpioOut_q;
    assign tx_data       = mem_q[rdPtr_q];
    assign tx_valid      = !empty;
`ifdef I2C_REG_BANK_IRQ_EN
    assign irq           = irq_q;
`else
    assign irq           = 1'b0;
`endif

endmodule
